glip_pattern_tester: RTL

Stream test engine attached to the GLIP FIFO interface of a board demo, in place of the plain wire loopback. It consumes the host-to-device stream (`fifo_in_*`) and produces the device-to-host stream (`fifo_out_*`). It offers four modes: buffered loopback, counting-pattern checker, counting-pattern generator, and checker plus generator. Counters and a sticky error flag drive board LEDs and allow host-side throughput and integrity tests.

---
 rtl/glip_pattern_tester.sv | 126 ++++++++++++
 1 files changed

// File: rtl/glip_pattern_tester.sv
// GLIP stream test engine: buffered loopback, counting-pattern checker and
// counting-pattern generator, with receive/error counters for host-side tests.
module glip_pattern_tester #(
    parameter int WIDTH = 8,
    parameter int ERRW  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      rx_cnt,
    output logic [ERRW-1:0]  err_cnt,
    output logic             error
);

    typedef enum logic {
        SYNC,
        CHECK
    } chk_state_t;

    chk_state_t       state, state_nxt;
    logic [1:0]       mode_q;
    logic             flush, loop_mode, chk_en, gen_en;
    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr, rd_ptr;
    logic [1:0]       count;
    logic [WIDTH-1:0] exp_q, gen;
    logic             in_xfer, out_xfer, push, pop, mismatch;
    logic             xfer_q, mism_q;

    assign flush     = (mode != mode_q);
    assign loop_mode = (mode == 2'b00);
    assign chk_en    = mode[0];
    assign gen_en    = mode[1];
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    assign push      = in_xfer && loop_mode;
    assign pop       = out_xfer && loop_mode;

    // Handshake outputs depend only on registered state, mode and rst.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        if (!rst) begin
            if (loop_mode) begin
                if (count != 2'd0) out_data = mem[rd_ptr];
                if (!flush) begin
                    in_ready  = (count != 2'd2);
                    out_valid = (count != 2'd0);
                end
            end else begin
                if (gen_en) out_data = gen;
                if (!flush) begin
                    in_ready  = 1'b1;
                    out_valid = gen_en;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        mismatch  = 1'b0;
        if (flush) begin
            state_nxt = SYNC;
        end else if (chk_en && in_xfer) begin
            state_nxt = CHECK;
            mismatch  = (state == CHECK) && (in_data != exp_q);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    // Counter updates run one stage behind the transfer, so a reset on the
    // following edge drops the in-flight word before it is counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= mode;
            state   <= SYNC;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
            exp_q   <= '0;
            gen     <= '0;
            xfer_q  <= 1'b0;
            mism_q  <= 1'b0;
            rx_cnt  <= '0;
            err_cnt <= '0;
            error   <= 1'b0;
        end else begin
            mode_q <= mode;
            state  <= state_nxt;
            xfer_q <= in_xfer;
            mism_q <= mismatch;
            if (xfer_q) rx_cnt <= rx_cnt + 32'd1;
            if (mism_q) begin
                error <= 1'b1;
                if (err_cnt != '1) err_cnt <= err_cnt + ERRW'(1);
            end
            if (chk_en && in_xfer) exp_q <= in_data + WIDTH'(1);
            if (gen_en && out_xfer) gen <= gen + WIDTH'(1);
            if (flush) begin
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
                count  <= 2'd0;
            end else begin
                if (push) wr_ptr <= ~wr_ptr;
                if (pop) rd_ptr <= ~rd_ptr;
                case ({push, pop})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule
